aes256_dec_fsm: RTL and testbench
=================================

# aes256_dec_fsm

Iterative AES-256 decryption core, the inverse-direction counterpart of the encryption FSM. It accepts one 128-bit ciphertext block on a one-cycle strobe and fetches the 15 round keys from an external key store in descending order (14 down to 0). It applies the FIPS-197 inverse cipher using a byte-serial inverse S-box and returns the plaintext with a one-cycle completion strobe. It sits between the AXI register front-end and the shared round-key storage, alongside the encryptor.

## Interface
- NR, 14, number of rounds; only 14 (AES-256) is required and verified.
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- ctrl_dataIn_dec  input  1  start strobe; sampled only in IDLE and HOLD.
- dec_dataIn  input  128  ciphertext; byte k = bits [8k+7:8k], state byte 4c+r = row r, column c.
- dec_key  input  128  round key addressed by dec_keyAddr; same byte mapping; combinational response from the key store, valid in the cycle after dec_keyAddr changes.
- dec_keyAddr  output  4  round-key index requested.
- dec_dataOut  output  128  plaintext, same byte mapping; held until the next completion.
- ctrl_dataOut_dec  output  1  one-cycle completion strobe.
- dec_busy  output  1  high in every state except IDLE.

## Operation
- Reset values: dec_dataOut=0, ctrl_dataOut_dec=0, dec_keyAddr=NR (14), dec_busy=0.
- Internal state: 128-bit state register, 128-bit substitution buffer, round counter, 5-bit byte counter, and an inverse S-box ROM with a 1-cycle registered read.
- States:
  - IDLE
    - dec_keyAddr=NR.
    - On ctrl_dataIn_dec=1: capture dec_dataIn into the state register, set round=NR, go to ARK.
  - ARK (1 cycle)
    - state ^= dec_key.
    - round==0 -> DONE; round==NR -> SUB; otherwise -> IMC.
  - IMC (1 cycle)
    - state = InvMixColumns(state).
    - Each column is multiplied by the matrix [0e 0b 0d 09] (rotating rows) over GF(2^8), polynomial 0x11b.
    - Go to SUB.
  - SUB (17 cycles)
    - Combines InvShiftRows and InvSubBytes.
    - Cycle j=0..15 presents source byte 4*((c-r) mod 4)+r to the ROM, where destination j=4c+r.
    - The ROM result is written to buffer byte j one cycle later; cycle 16 drains the last byte.
    - On the last cycle: state=buffer, round and dec_keyAddr decrement, go to ARK.
  - DONE (1 cycle)
    - dec_dataOut<=state, ctrl_dataOut_dec<=1 (registered).
    - Go to HOLD.
  - HOLD
    - ctrl_dataOut_dec returns to 0.
    - Stay while ctrl_dataIn_dec=1; go to IDLE when it is 0.
- Round order: ARK(14), SUB, then for r=13..1: ARK(r), IMC, SUB; final ARK(0).
- dec_keyAddr sequence: 14,13,...,0. It holds 0 through DONE and HOLD and returns to 14 on entering IDLE.
- ctrl_dataIn_dec is ignored in ARK, IMC, SUB and DONE. No queuing and no abort.
- Asserting resetn low at any point returns all outputs and state to reset values immediately. The next start is accepted normally after release.

## Timing
- Edge 0: the edge that samples ctrl_dataIn_dec=1 in IDLE.
- ARK(14) occurs at edge 1.
- SUB occupies edges 2-18.
- Each of rounds 13..1 takes 19 edges (ARK, IMC, SUB 17) and occupies edges 19-265.
- ARK(0) occurs at edge 266.
- DONE occurs at edge 267.
- ctrl_dataOut_dec is high and dec_dataOut is valid from edge 267 to edge 268. Latency = 19*NR+1 = 267 cycles.
- dec_busy rises at edge 0 and falls on the edge entering IDLE.
- Minimum start-to-start interval is 269 cycles: ctrl_dataIn_dec must be low at edge 268, then high again.
- The key is sampled at the ARK edge and must be stable in the cycle preceding it.

## Test plan
- FIPS-197 C.3 vector:
  - Stimulus: dec_dataIn=128'h8960494b9049fceabf456751cab7a28e; bench serves the expanded key of 000102..1f at addresses 0-14.
  - Required: ctrl_dataOut_dec high exactly 267 cycles after start, dec_dataOut=128'hffeeddccbbaa99887766554433221100.
- Key address trace:
  - Stimulus: run the same vector.
  - Required: dec_keyAddr=14 from edge 0 to edge 18, then decrements by 1 every 19 cycles. It equals 0 at ARK(0) (edge 266) and 14 again after returning to IDLE.
- Held start:
  - Stimulus: hold ctrl_dataIn_dec=1 for 400 cycles.
  - Required: exactly one ctrl_dataOut_dec pulse, dec_busy stays 1 until ctrl drops, a second pulse appears only after a new rising strobe.
- Ignored strobe:
  - Stimulus: pulse ctrl_dataIn_dec with a different dec_dataIn at cycle 100.
  - Required: output still equals the first block's plaintext.
- Mid-operation reset:
  - Stimulus: assert resetn=0 at cycle 150.
  - Required: dec_dataOut=0, ctrl_dataOut_dec=0, dec_busy=0, dec_keyAddr=14 immediately. After release, the C.3 vector decrypts correctly.
- Round trip:
  - Stimulus: 20 random plaintext/key pairs, each encrypted by the encryptor model and then fed to this block.
  - Required: every dec_dataOut equals the original plaintext.

Source files
------------

// File: rtl/aes256_dec_fsm.sv
// Iterative AES-256 inverse cipher: one round key per ARK step (fetched 14..0),
// InvShiftRows+InvSubBytes folded into a byte-serial pass through a registered inverse S-box.
module aes256_dec_fsm #(
   parameter int unsigned NR = 14
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         ctrl_dataIn_dec,
   input  logic [127:0] dec_dataIn,
   input  logic [127:0] dec_key,
   output logic [3:0]   dec_keyAddr,
   output logic [127:0] dec_dataOut,
   output logic         ctrl_dataOut_dec,
   output logic         dec_busy,
   output logic [2:0]   fsm_state
);

   localparam logic [3:0] NR_L = 4'(NR);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARK  = 3'd1;
   localparam logic [2:0] S_IMC  = 3'd2;
   localparam logic [2:0] S_SUB  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_HOLD = 3'd5;

   logic [2:0]   st;
   logic [127:0] state_q;
   logic [127:0] buf_q;
   logic [3:0]   round_q;
   logic [4:0]   cnt_q;
   logic [7:0]   rom_q;

   logic [1:0]   src_col;
   logic [3:0]   src_idx;
   logic [3:0]   wr_idx;
   logic [7:0]   src_byte;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse affine map followed by the multiplicative inverse (a^254; zero maps to zero).
   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      logic [7:0] a;
      logic [7:0] p;
      logic [7:0] r;
      a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];
         a1 = s[32*c+8 +: 8];
         a2 = s[32*c+16 +: 8];
         a3 = s[32*c+24 +: 8];
         o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Destination byte 4c+r takes source column (c-r) mod 4 of the same row.
   assign src_col  = cnt_q[3:2] - cnt_q[1:0];
   assign src_idx  = {src_col, cnt_q[1:0]};
   assign src_byte = state_q[{src_idx, 3'b000} +: 8];
   assign wr_idx   = cnt_q[3:0] - 4'd1;

   assign dec_busy  = (st != S_IDLE);
   assign fsm_state = st;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st               <= S_IDLE;
         state_q          <= '0;
         buf_q            <= '0;
         round_q          <= NR_L;
         cnt_q            <= '0;
         rom_q            <= '0;
         dec_keyAddr      <= NR_L;
         dec_dataOut      <= '0;
         ctrl_dataOut_dec <= 1'b0;
      end else begin
         rom_q            <= inv_sbox(src_byte);
         ctrl_dataOut_dec <= 1'b0;
         case (st)
            S_IDLE: begin
               dec_keyAddr <= NR_L;
               cnt_q       <= '0;
               if (ctrl_dataIn_dec) begin
                  state_q <= dec_dataIn;
                  round_q <= NR_L;
                  st      <= S_ARK;
               end
            end
            S_ARK: begin
               state_q <= state_q ^ dec_key;
               cnt_q   <= '0;
               if (round_q == 4'd0)       st <= S_DONE;
               else if (round_q == NR_L)  st <= S_SUB;
               else                       st <= S_IMC;
            end
            S_IMC: begin
               state_q <= inv_mix(state_q);
               st      <= S_SUB;
            end
            S_SUB: begin
               // ROM output lags the address by one cycle, so byte j lands on count j+1.
               if (cnt_q != 5'd0) buf_q[{wr_idx, 3'b000} +: 8] <= rom_q;
               if (cnt_q == 5'd16) begin
                  state_q     <= {rom_q, buf_q[119:0]};
                  round_q     <= round_q - 4'd1;
                  dec_keyAddr <= dec_keyAddr - 4'd1;
                  st          <= S_ARK;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            S_DONE: begin
               dec_dataOut      <= state_q;
               ctrl_dataOut_dec <= 1'b1;
               st               <= S_HOLD;
            end
            S_HOLD: begin
               if (!ctrl_dataIn_dec) begin
                  dec_keyAddr <= NR_L;
                  st          <= S_IDLE;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes256_dec_fsm.sv
// Directed bench for aes256_dec_fsm: serves round keys from a reference key expansion and
// checks plaintext, latency, key-address trace, strobe handling and reset behaviour.
module tb_aes256_dec_fsm;

   logic         clk;
   logic         resetn;
   logic         ctrl_dataIn_dec;
   logic [127:0] dec_dataIn;
   logic [127:0] dec_key;
   logic [3:0]   dec_keyAddr;
   logic [127:0] dec_dataOut;
   logic         ctrl_dataOut_dec;
   logic         dec_busy;
   logic [2:0]   fsm_state;

   int tests = 0;
   int fails = 0;

   logic [127:0] rk_mem [0:15];
   logic [7:0]   sb [256];
   logic [127:0] exp_q [$];

   localparam logic [127:0] C3_CT = 128'h8960494b9049fceabf456751cab7a28e;
   localparam logic [127:0] C3_PT = 128'hffeeddccbbaa99887766554433221100;

   aes256_dec_fsm dut (
      .clk              (clk),
      .resetn           (resetn),
      .ctrl_dataIn_dec  (ctrl_dataIn_dec),
      .dec_dataIn       (dec_dataIn),
      .dec_key          (dec_key),
      .dec_keyAddr      (dec_keyAddr),
      .dec_dataOut      (dec_dataOut),
      .ctrl_dataOut_dec (ctrl_dataOut_dec),
      .dec_busy         (dec_busy),
      .fsm_state        (fsm_state)
   );

   // Key store answers combinationally from the requested address.
   assign dec_key = rk_mem[dec_keyAddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box by brute-force inverse search plus the forward affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                     ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   task automatic load_key(input logic [255:0] key);
      logic [7:0] w [60][4];
      logic [7:0] t [4];
      logic [7:0] t0;
      logic [7:0] rc;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
      rc = 8'h01;
      for (int i = 8; i < 60; i++) begin
         for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
         if (i % 8 == 0) begin
            t0 = t[0];
            t[0] = sb[t[1]] ^ rc;
            t[1] = sb[t[2]];
            t[2] = sb[t[3]];
            t[3] = sb[t0];
            rc = gm(rc, 8'h02);
         end else if (i % 8 == 4) begin
            for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
         end
         for (int j = 0; j < 4; j++) w[i][j] = w[i-8][j] ^ t[j];
      end
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) rk_mem[r][8*(4*c+j) +: 8] = w[4*r+c][j];
      rk_mem[15] = 'x;
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] o;
      for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ rk_mem[0][8*k +: 8];
      for (int r = 1; r <= 14; r++) begin
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) t[4*c+q] = sb[s[4*((c+q)%4)+q]];
         for (int c = 0; c < 4; c++) begin
            if (r != 14) begin
               s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
               s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
            end else begin
               for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
            end
         end
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_mem[r][8*k +: 8];
      end
      for (int k = 0; k < 16; k++) o[8*k +: 8] = s[k];
      return o;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_c3_key();
      logic [255:0] k;
      for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
      load_key(k);
   endtask

   // Drives a one-cycle start; returns at the negedge after the sampling edge (edge 0).
   task automatic start_block(input logic [127:0] ct);
      @(negedge clk);
      dec_dataIn      = ct;
      ctrl_dataIn_dec = 1'b1;
      @(negedge clk);
      ctrl_dataIn_dec = 1'b0;
   endtask

   // Follows one block from edge 0 to its completion strobe; optionally injects a strobe.
   task automatic wait_done(input int inj_cyc, input logic [127:0] inj_data,
                            output int lat, output int trace_bad);
      logic [3:0] ea;
      lat = -1;
      trace_bad = 0;
      for (int cyc = 0; cyc <= 400; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == inj_cyc) begin
            dec_dataIn      = inj_data;
            ctrl_dataIn_dec = 1'b1;
         end else if (cyc == inj_cyc + 1) begin
            ctrl_dataIn_dec = 1'b0;
         end
         if (cyc < 18)       ea = 4'd14;
         else if (cyc >= 265) ea = 4'd0;
         else                ea = 4'(13 - (cyc - 18) / 19);
         if (dec_keyAddr !== ea || dec_busy !== 1'b1) trace_bad++;
         if (ctrl_dataOut_dec === 1'b1) begin
            lat = cyc;
            check("sb_depth", 128'(exp_q.size()), 128'd1);
            if (exp_q.size() > 0) check("plaintext", dec_dataOut, exp_q.pop_front());
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int bad;
      int pulses;
      int busy_low;
      logic [127:0] pt_a;
      logic [127:0] ct_a;
      logic [255:0] rkey;

      resetn          = 1'b0;
      ctrl_dataIn_dec = 1'b0;
      dec_dataIn      = '0;
      build_sbox();
      load_c3_key();
      repeat (3) @(negedge clk);

      check("rst_dataOut", dec_dataOut, 128'd0);
      check("rst_strobe", 128'(ctrl_dataOut_dec), 128'd0);
      check("rst_keyAddr", 128'(dec_keyAddr), 128'd14);
      check("rst_busy", 128'(dec_busy), 128'd0);
      check("rst_fsm_state", 128'(fsm_state), 128'd0);
      resetn = 1'b1;
      @(negedge clk);

      check("model_c3_encrypt", encrypt(C3_PT), C3_CT);

      // FIPS-197 C.3 with latency and key-address trace
      exp_q.push_back(C3_PT);
      start_block(C3_CT);
      wait_done(-1, '0, lat, bad);
      check("c3_latency", 128'(lat), 128'd267);
      check("c3_keyaddr_trace", 128'(bad), 128'd0);
      @(negedge clk);
      check("c3_strobe_width", 128'(ctrl_dataOut_dec), 128'd0);
      @(negedge clk);
      check("c3_idle_busy", 128'(dec_busy), 128'd0);
      check("c3_idle_keyaddr", 128'(dec_keyAddr), 128'd14);
      check("c3_data_held", dec_dataOut, C3_PT);

      // Held start strobe for 400 cycles
      exp_q.push_back(C3_PT);
      @(negedge clk);
      dec_dataIn      = C3_CT;
      ctrl_dataIn_dec = 1'b1;
      pulses   = 0;
      busy_low = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (dec_busy !== 1'b1) busy_low++;
         if (ctrl_dataOut_dec === 1'b1) begin
            pulses++;
            if (exp_q.size() > 0) check("held_plaintext", dec_dataOut, exp_q.pop_front());
         end
      end
      check("held_pulses", 128'(pulses), 128'd1);
      check("held_busy", 128'(busy_low), 128'd0);
      ctrl_dataIn_dec = 1'b0;
      @(negedge clk);
      check("held_release_idle", 128'(dec_busy), 128'd0);
      exp_q.push_back(C3_PT);
      start_block(C3_CT);
      wait_done(-1, '0, lat, bad);
      check("held_second_latency", 128'(lat), 128'd267);
      repeat (2) @(negedge clk);

      // Strobe with different data mid-operation is ignored
      pt_a = {$urandom, $urandom, $urandom, $urandom};
      ct_a = encrypt(pt_a);
      exp_q.push_back(pt_a);
      start_block(ct_a);
      wait_done(100, C3_CT, lat, bad);
      check("ignored_latency", 128'(lat), 128'd267);
      check("ignored_trace", 128'(bad), 128'd0);
      repeat (2) @(negedge clk);

      // Reset in the middle of a block
      start_block(C3_CT);
      repeat (150) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("midrst_dataOut", dec_dataOut, 128'd0);
      check("midrst_strobe", 128'(ctrl_dataOut_dec), 128'd0);
      check("midrst_busy", 128'(dec_busy), 128'd0);
      check("midrst_keyAddr", 128'(dec_keyAddr), 128'd14);
      @(negedge clk);
      resetn = 1'b1;
      exp_q.push_back(C3_PT);
      start_block(C3_CT);
      wait_done(-1, '0, lat, bad);
      check("midrst_c3_latency", 128'(lat), 128'd267);
      repeat (2) @(negedge clk);

      // Round trip through the reference encryptor
      for (int n = 0; n < 20; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         load_key(rkey);
         pt_a = {$urandom, $urandom, $urandom, $urandom};
         ct_a = encrypt(pt_a);
         exp_q.push_back(pt_a);
         start_block(ct_a);
         wait_done(-1, '0, lat, bad);
         check("rt_latency", 128'(lat), 128'd267);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      check("sb_drained", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
